// File: rtl/pipe_stage.sv
// Elastic pipeline register: 1-cycle latency, NOP presented when empty, stall bubbles and holds, flush kills.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer with registered in_ready.
module pipe_stage #(
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 64,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h0000_0013)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               stall,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [15:0]        stall_cnt,
  output logic [7:0]         flush_cnt
);

  logic               main_valid, main_valid_d;
  logic [INSTR_W-1:0] main_instr, main_instr_d;
  logic [PC_W-1:0]    main_pc, main_pc_d;
  logic               accept, drain;
  logic [15:0]        stall_q;
  logic [7:0]         flush_q;

  assign out_valid = main_valid & ~stall;
  assign drain     = out_valid & out_ready;
  assign accept    = in_valid & in_ready & ~stall & ~flush;
  assign out_instr = main_valid ? main_instr : NOP_INSTR;
  assign out_pc    = main_valid ? main_pc : '0;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

`ifdef PIPE_STAGE_SKID_EN
  logic               skid_valid, skid_valid_d;
  logic [INSTR_W-1:0] skid_instr, skid_instr_d;
  logic [PC_W-1:0]    skid_pc, skid_pc_d;
  logic               rdy_q;

  // Registered ready only looks at local state; stall and reset still gate it.
  assign in_ready = rdy_q & ~stall & ~rst;

  always_comb begin
    main_valid_d = main_valid;
    main_instr_d = main_instr;
    main_pc_d    = main_pc;
    skid_valid_d = skid_valid;
    skid_instr_d = skid_instr;
    skid_pc_d    = skid_pc;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (drain) begin
      if (skid_valid) begin
        main_instr_d = skid_instr;
        main_pc_d    = skid_pc;
        skid_valid_d = accept;
        skid_instr_d = in_instr;
        skid_pc_d    = in_pc;
      end else if (accept) begin
        main_instr_d = in_instr;
        main_pc_d    = in_pc;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (main_valid) begin
        skid_valid_d = 1'b1;
        skid_instr_d = in_instr;
        skid_pc_d    = in_pc;
      end else begin
        main_valid_d = 1'b1;
        main_instr_d = in_instr;
        main_pc_d    = in_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      skid_valid <= skid_valid_d;
      rdy_q      <= ~skid_valid_d;
    end
    skid_instr <= skid_instr_d;
    skid_pc    <= skid_pc_d;
  end
`else
  assign in_ready = ~rst & ~stall & (~main_valid | out_ready);

  always_comb begin
    main_valid_d = main_valid;
    main_instr_d = main_instr;
    main_pc_d    = main_pc;
    if (flush) begin
      main_valid_d = 1'b0;
    end else if (accept) begin
      main_valid_d = 1'b1;
      main_instr_d = in_instr;
      main_pc_d    = in_pc;
    end else if (drain) begin
      main_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
    end else begin
      main_valid <= main_valid_d;
    end
    main_instr <= main_instr_d;
    main_pc    <= main_pc_d;
  end

  // Only stalls that actually hold an instruction are worth counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall && main_valid && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      if (flush && flush_q != 8'hFF) flush_q <= flush_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// Scoreboard bench for pipe_stage: directed stimulus pushes expected items, a negedge monitor pops on each drain.
module tb_pipe_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, stall, flush, out_valid, out_ready;
  logic [31:0] in_instr, out_instr;
  logic [63:0] in_pc, out_pc;
  logic [15:0] stall_cnt;
  logic [7:0]  flush_cnt;

  int          checks = 0;
  int          passes = 0;
  logic [95:0] exp_q[$];
  logic [95:0] mon_e;

  always #5 clk = ~clk;

  pipe_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [63:0] p,
                       input logic ordy, input logic stl, input logic fl);
    in_valid  = v;
    in_instr  = i;
    in_pc     = p;
    out_ready = ordy;
    stall     = stl;
    flush     = fl;
  endtask

  task automatic sample(input logic exp_rdy, input bit keep);
    @(negedge clk);
    check("in_ready", {63'b0, in_ready}, {63'b0, exp_rdy});
    if (keep && in_valid && exp_rdy && !stall && !flush) exp_q.push_back({in_instr, in_pc});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic v, input logic [31:0] i, input logic [63:0] p,
                     input logic ordy, input logic exp_rdy);
    drive(v, i, p, ordy, 1'b0, 1'b0);
    sample(exp_rdy, 1'b1);
    tick();
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_output: got pc 0x%0h, expected no output", out_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_instr", {32'b0, out_instr}, {32'b0, mon_e[95:64]});
        check("out_pc", out_pc, mon_e[63:0]);
      end
    end
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {63'b0, out_valid}, 64'h0);
    check("rst_out_instr", {32'b0, out_instr}, {32'b0, NOP});
    check("rst_out_pc", out_pc, 64'h0);
    check("rst_stall_cnt", {48'b0, stall_cnt}, 64'h0);
    check("rst_flush_cnt", {56'b0, flush_cnt}, 64'h0);
    check("rst_in_ready", {63'b0, in_ready}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Streaming back-to-back
    cyc(1'b1, 32'h0050_0093, 64'h0, 1'b1, 1'b1);
    drive(1'b1, 32'h00A0_0113, 64'h4, 1'b1, 1'b0, 1'b0);
    sample(1'b1, 1'b1);
    check("stream_gap0", {63'b0, out_valid}, 64'h1);
    tick();
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    sample(1'b1, 1'b1);
    check("stream_gap1", {63'b0, out_valid}, 64'h1);
    tick();
    sample(1'b1, 1'b1);
    check("stream_empty_valid", {63'b0, out_valid}, 64'h0);
    check("stream_empty_nop", {32'b0, out_instr}, {32'b0, NOP});
    tick();

    // Backpressure
`ifdef PIPE_STAGE_SKID_EN
    cyc(1'b1, 32'h0010_0193, 64'h10, 1'b0, 1'b1);
    cyc(1'b1, 32'h0020_0213, 64'h14, 1'b0, 1'b1);
    cyc(1'b1, 32'h0030_0293, 64'h18, 1'b0, 1'b0);
    cyc(1'b1, 32'h0030_0293, 64'h18, 1'b1, 1'b0);
    cyc(1'b1, 32'h0030_0293, 64'h18, 1'b1, 1'b1);
`else
    cyc(1'b1, 32'h0010_0193, 64'h10, 1'b0, 1'b1);
    cyc(1'b1, 32'h0020_0213, 64'h14, 1'b0, 1'b0);
    cyc(1'b1, 32'h0020_0213, 64'h14, 1'b0, 1'b0);
    cyc(1'b1, 32'h0020_0213, 64'h14, 1'b1, 1'b1);
    cyc(1'b1, 32'h0030_0293, 64'h18, 1'b1, 1'b1);
`endif
    cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b1);

    // Stall holding pc=0x8
    cyc(1'b1, 32'h0000_0513, 64'h8, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      sample(1'b0, 1'b1);
      check("stall_out_valid", {63'b0, out_valid}, 64'h0);
      tick();
    end
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    sample(1'b1, 1'b1);
    check("stall_cnt_3", {48'b0, stall_cnt}, 64'd3);
    check("stall_release_valid", {63'b0, out_valid}, 64'h1);
    check("stall_release_pc", out_pc, 64'h8);
    tick();

    // Flush together with stall and an offered item
    drive(1'b1, 32'h00C0_0613, 64'hC, 1'b0, 1'b0, 1'b0);
    sample(1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h0010_0693, 64'h20, 1'b0, 1'b1, 1'b1);
    sample(1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    sample(1'b1, 1'b1);
    check("flush_out_valid", {63'b0, out_valid}, 64'h0);
    check("flush_out_nop", {32'b0, out_instr}, {32'b0, NOP});
    check("flush_out_pc", out_pc, 64'h0);
    check("flush_cnt_1", {56'b0, flush_cnt}, 64'd1);
    check("stall_cnt_4", {48'b0, stall_cnt}, 64'd4);
    tick();
    // Flush with in_ready high: offered item must still be dropped
    drive(1'b1, 32'h0140_0713, 64'h24, 1'b1, 1'b0, 1'b1);
    sample(1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    sample(1'b1, 1'b1);
    check("flush2_out_valid", {63'b0, out_valid}, 64'h0);
    check("flush_cnt_2", {56'b0, flush_cnt}, 64'd2);
    tick();

    // Stall counter saturation
    cyc(1'b1, 32'h01E0_0793, 64'h30, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b1, 1'b0);
    repeat (1000) @(posedge clk);
    @(negedge clk);
    check("stall_cnt_1004", {48'b0, stall_cnt}, 64'd1004);
    repeat (69000) @(posedge clk);
    @(negedge clk);
    check("stall_cnt_sat", {48'b0, stall_cnt}, 64'hFFFF);
    tick();
    cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b1);

    // Flush counter saturation
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b1);
    repeat (300) @(posedge clk);
    #1;
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("flush_cnt_sat", {56'b0, flush_cnt}, 64'hFF);
    check("stall_cnt_hold", {48'b0, stall_cnt}, 64'hFFFF);
    tick();

    // Reset while holding an item
    drive(1'b1, 32'h0280_0813, 64'h40, 1'b0, 1'b0, 1'b0);
    sample(1'b1, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    check("rst2_out_valid", {63'b0, out_valid}, 64'h0);
    check("rst2_out_pc", out_pc, 64'h0);
    check("rst2_stall_cnt", {48'b0, stall_cnt}, 64'h0);
    check("rst2_flush_cnt", {56'b0, flush_cnt}, 64'h0);
    check("rst2_in_ready", {63'b0, in_ready}, 64'h0);
    tick();
    rst = 1'b0;
    cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b1);

    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
